csam_16x12_tc: RTL and testbench



---
 rtl/csam_16x12_tc.sv | 68 ++++++
 tb/tb_csam_16x12_tc.sv | 100 ++++++++++
 2 files changed

// File: rtl/csam_16x12_tc.sv
// Signed 16x12 carry-save array multiplier with Baugh-Wooley sign handling
// and a ripple-carry vector-merge adder; combinational Z plus registered Z_r.
module csam_16x12_tc (
  input  logic        clk,
  input  logic        reset,
  output logic [27:0] Z,
  input  logic [15:0] X,
  input  logic [11:0] Y,
  output logic [27:0] Z_r
);

  localparam int unsigned XW = 16;
  localparam int unsigned YW = 12;
  localparam int unsigned ZW = 28;

  // Baugh-Wooley correction: constant ones at columns 11, 15 and 27
  localparam logic [ZW-1:0] BW_CORR = (ZW'(1) << 27) | (ZW'(1) << 15) | (ZW'(1) << 11);

  logic [XW-1:0] pp [YW];
  logic [ZW-1:0] sv [YW];
  logic [ZW-1:0] cv [YW];
  logic [ZW-1:0] z_sum;

  // Partial products; sign-row/sign-column terms are complemented, the corner term is not
  always_comb begin : pp_gen
    for (int unsigned j = 0; j < YW; j++) begin
      for (int unsigned i = 0; i < XW; i++) begin
        pp[j][i] = (X[i] & Y[j]) ^ ((i == XW - 1) != (j == YW - 1));
      end
    end
  end

  // Carry-save array: the correction constant rides in as the initial carry vector,
  // each of the 11 rows adds one shifted partial-product row, carries move one column left
  always_comb begin : csa_array
    logic [ZW-1:0] row;
    logic [ZW-1:0] maj;
    row   = '0;
    maj   = '0;
    sv[0] = ZW'(pp[0]);
    cv[0] = BW_CORR;
    for (int unsigned j = 1; j < YW; j++) begin
      row   = ZW'(pp[j]) << j;
      sv[j] = sv[j-1] ^ cv[j-1] ^ row;
      maj   = (sv[j-1] & cv[j-1]) | (sv[j-1] & row) | (cv[j-1] & row);
      cv[j] = {maj[ZW-2:0], 1'b0};
    end
  end

  // Vector-merge ripple-carry adder; carry out of column 27 is dropped
  always_comb begin : vma
    logic c;
    c     = 1'b0;
    z_sum = '0;
    for (int unsigned k = 0; k < ZW; k++) begin
      z_sum[k] = sv[YW-1][k] ^ cv[YW-1][k] ^ c;
      c        = (sv[YW-1][k] & cv[YW-1][k]) | (sv[YW-1][k] & c) | (cv[YW-1][k] & c);
    end
  end

  assign Z = z_sum;

  always_ff @(posedge clk) begin
    if (reset) Z_r <= '0;
    else       Z_r <= Z;
  end

endmodule

// File: tb/tb_csam_16x12_tc.sv
// Directed and random checks of csam_16x12_tc: Z at the falling edge,
// Z_r one cycle later through a scoreboard queue.
module tb_csam_16x12_tc;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] X;
  logic [11:0] Y;
  logic [27:0] Z;
  logic [27:0] Z_r;

  int tests  = 0;
  int failed = 0;
  logic [27:0] zr_q [$];

  csam_16x12_tc dut (
    .clk  (clk),
    .reset(reset),
    .Z    (Z),
    .X    (X),
    .Y    (Y),
    .Z_r  (Z_r)
  );

  always #10 clk = ~clk;

  function automatic logic [27:0] golden(input logic [15:0] x, input logic [11:0] y);
    logic signed [27:0] xs;
    logic signed [27:0] ys;
    xs = 28'($signed(x));
    ys = 28'($signed(y));
    return 28'(xs * ys);
  endfunction

  task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one vector 1 ns after the edge, check the previous vector's Z_r, then Z at negedge
  task automatic step(input logic [15:0] x, input logic [11:0] y, input logic [27:0] expv,
                      input string tag);
    @(posedge clk);
    #1;
    if (zr_q.size() > 0) check({tag, "_zr_prev"}, Z_r, zr_q.pop_front());
    X = x;
    Y = y;
    zr_q.push_back(expv);
    @(negedge clk);
    check(tag, Z, expv);
  endtask

  initial begin
    reset = 1'b1;
    X     = '0;
    Y     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_zr", Z_r, 28'h0000000);
    reset = 1'b0;

    step(16'h7FFF, 12'h7FF, 28'h3FF7801, "max_pos");
    step(16'h8000, 12'h800, 28'h4000000, "both_min");
    step(16'h8000, 12'h7FF, 28'hC008000, "min_x_max_y");
    step(16'hFFFF, 12'h001, 28'hFFFFFFF, "neg_one");
    step(16'h0003, 12'hFFE, 28'hFFFFFFA, "neg_six");
    step(16'h1234, 12'h000, 28'h0000000, "zero_y");
    step(16'h7FFF, 12'h7FF, 28'h3FF7801, "pre_reset");

    // Reset for one edge clears Z_r only; Z keeps tracking the inputs
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_reset_zr", Z_r, 28'h0000000);
    check("mid_reset_z", Z, 28'h3FF7801);
    zr_q.delete();
    reset = 1'b0;
    zr_q.push_back(28'h3FF7801);

    for (int n = 0; n < 256; n++) begin
      logic [15:0] rx;
      logic [11:0] ry;
      rx = 16'($urandom);
      ry = 12'($urandom);
      step(rx, ry, golden(rx, ry), "rand");
    end

    @(posedge clk);
    #1;
    if (zr_q.size() > 0) check("final_zr", Z_r, zr_q.pop_front());

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
